// File: rtl/zmod_rx_checker.sv
// Receive-side pattern checker for the LVDS loopback path: locks onto the transmitter's
// free-running modulo-2^WIDTH up-counter, flywheels through isolated errors, counts words and errors.
module zmod_rx_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             clear_counts,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count,
    output logic [1:0]       state
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W = $clog2(LOSS_COUNT + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(LOSS_COUNT - 1);

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] prev_q,    prev_d;
    logic [RUN_W-1:0] run_q,     run_d;
    logic [BAD_W-1:0] bad_q,     bad_d;
    logic             locked_q,  locked_d;
    logic             error_q,   error_d;
    logic [CNT_W-1:0] errCnt_q,  errCnt_d;
    logic [CNT_W-1:0] wordCnt_q, wordCnt_d;

    logic [WIDTH-1:0] expected;
    logic             match;
    logic             errInc;
    logic             wordInc;

    assign expected = prev_q + WIDTH'(1);
    assign match    = (din == expected);

    // CHECK reseeds from din on every word; LOCKED flywheels on its own prediction
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        run_d    = run_q;
        bad_d    = bad_q;
        locked_d = locked_q;
        error_d  = 1'b0;
        errInc   = 1'b0;
        wordInc  = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    prev_d  = din;
                    run_d   = '0;
                    state_d = CHECK;
                end
                CHECK: begin
                    prev_d = din;
                    if (match) begin
                        run_d = run_q + 1'b1;
                        if (run_q == RUN_LAST) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    prev_d  = expected;
                    wordInc = 1'b1;
                    if (match) begin
                        bad_d = '0;
                    end else begin
                        error_d = 1'b1;
                        errInc  = 1'b1;
                        if (bad_q == BAD_LAST) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            run_d    = '0;
                            bad_d    = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // Clear wins over a coincident increment; counters stick at all-ones
    always_comb begin
        errCnt_d  = errCnt_q;
        wordCnt_d = wordCnt_q;
        if (clear_counts) begin
            errCnt_d  = '0;
            wordCnt_d = '0;
        end else begin
            if (errInc && (errCnt_q != '1)) begin
                errCnt_d = errCnt_q + 1'b1;
            end
            if (wordInc && (wordCnt_q != '1)) begin
                wordCnt_d = wordCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            prev_q    <= '0;
            run_q     <= '0;
            bad_q     <= '0;
            locked_q  <= 1'b0;
            error_q   <= 1'b0;
            errCnt_q  <= '0;
            wordCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            run_q     <= run_d;
            bad_q     <= bad_d;
            locked_q  <= locked_d;
            error_q   <= error_d;
            errCnt_q  <= errCnt_d;
            wordCnt_q <= wordCnt_d;
        end
    end

    assign locked     = locked_q;
    assign error      = error_q;
    assign err_count  = errCnt_q;
    assign word_count = wordCnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_zmod_rx_checker.sv
// Scoreboard bench for zmod_rx_checker: default instance for lock/loss/gap/clear/reset scenarios,
// a narrow-counter instance (CNT_W=4, LOSS_COUNT=32, LOCK_COUNT=1) for saturation.
module tb_zmod_rx_checker;

    localparam logic [1:0] S_HUNT   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN, dinValid, clearCounts;
    logic [7:0]  din;
    logic        locked, error;
    logic [31:0] errCount, wordCount;
    logic [1:0]  state;

    logic        rst2N, valid2, clear2;
    logic [7:0]  din2;
    logic        locked2, error2;
    logic [3:0]  errCount2, wordCount2;
    logic [1:0]  state2;

    zmod_rx_checker dut (
        .clk(clk), .rst_n(rstN), .din(din), .din_valid(dinValid), .clear_counts(clearCounts),
        .locked(locked), .error(error), .err_count(errCount), .word_count(wordCount), .state(state)
    );

    zmod_rx_checker #(.WIDTH(8), .LOCK_COUNT(1), .LOSS_COUNT(32), .CNT_W(4)) dutSat (
        .clk(clk), .rst_n(rst2N), .din(din2), .din_valid(valid2), .clear_counts(clear2),
        .locked(locked2), .error(error2), .err_count(errCount2), .word_count(wordCount2), .state(state2)
    );

    typedef struct {
        logic        lk;
        logic        er;
        logic [31:0] ec;
        logic [31:0] wc;
        logic [1:0]  st;
    } expT;

    expT q1[$];
    expT q2[$];
    expT e1, e2;
    int  checks = 0;
    int  fails  = 0;
    int  n1 = 0;
    int  n2 = 0;
    int  ec, wc;

    function automatic void checkOutput(string tag, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s (response %0d): got 0x%0h, expected 0x%0h", tag, idx, act, exp);
        end
    endfunction

    // Monitors pop one expected response per clock the stimulus produced
    always @(negedge clk) begin
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            n1++;
            checkOutput("main.locked", n1, 32'(locked), 32'(e1.lk));
            checkOutput("main.error",  n1, 32'(error),  32'(e1.er));
            checkOutput("main.errCnt", n1, errCount,    e1.ec);
            checkOutput("main.wordCnt", n1, wordCount,  e1.wc);
            checkOutput("main.state",  n1, 32'(state),  32'(e1.st));
        end
    end

    always @(negedge clk) begin
        if (q2.size() > 0) begin
            e2 = q2.pop_front();
            n2++;
            checkOutput("sat.locked", n2, 32'(locked2),    32'(e2.lk));
            checkOutput("sat.error",  n2, 32'(error2),     32'(e2.er));
            checkOutput("sat.errCnt", n2, 32'(errCount2),  e2.ec);
            checkOutput("sat.wordCnt", n2, 32'(wordCount2), e2.wc);
            checkOutput("sat.state",  n2, 32'(state2),     32'(e2.st));
        end
    end

    task automatic applyStimulus(input logic r, input logic [7:0] d, input logic v, input logic c,
                                 input logic lk, input logic er, input int expEc, input int expWc,
                                 input logic [1:0] st);
        rstN = r; din = d; dinValid = v; clearCounts = c;
        @(posedge clk);
        q1.push_back('{lk, er, 32'(expEc), 32'(expWc), st});
        #1;
    endtask

    task automatic applyStimulusSat(input logic r, input logic [7:0] d, input logic v, input logic c,
                                    input logic lk, input logic er, input int expEc, input int expWc,
                                    input logic [1:0] st);
        rst2N = r; din2 = d; valid2 = v; clear2 = c;
        @(posedge clk);
        q2.push_back('{lk, er, 32'(expEc), 32'(expWc), st});
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0; din = '0; dinValid = 1'b0; clearCounts = 1'b0;
        rst2N = 1'b0; din2 = '0; valid2 = 1'b0; clear2 = 1'b0;

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, S_HUNT);

        // Acquire across the 0xFF -> 0x00 wrap: 0xF5 seeds, 16 matches to 0x05 lock
        for (int k = 0; k <= 16; k++)
            applyStimulus(1'b1, 8'(8'hF5 + k), 1'b1, 1'b0, (k == 16), 1'b0, 0, 0,
                          (k == 16) ? S_LOCKED : S_CHECK);

        ec = 0; wc = 0;
        for (int d = 8'h06; d <= 8'h11; d++) begin
            wc++;
            applyStimulus(1'b1, 8'(d), 1'b1, 1'b0, 1'b1, 1'b0, ec, wc, S_LOCKED);
        end
        ec++; wc++;
        applyStimulus(1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b1, ec, wc, S_LOCKED);
        wc++;
        applyStimulus(1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0, ec, wc, S_LOCKED);
        wc++;
        applyStimulus(1'b1, 8'h14, 1'b1, 1'b0, 1'b1, 1'b0, ec, wc, S_LOCKED);
        for (int d = 8'h15; d <= 8'h20; d++) begin
            wc++;
            applyStimulus(1'b1, 8'(d), 1'b1, 1'b0, 1'b1, 1'b0, ec, wc, S_LOCKED);
        end

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, ec, wc, S_LOCKED);
        wc++;
        applyStimulus(1'b1, 8'h21, 1'b1, 1'b0, 1'b1, 1'b0, ec, wc, S_LOCKED);

        ec = 0; wc = 0;
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, ec, wc, S_LOCKED);

        // Four consecutive mismatches drop lock on the fourth
        for (int i = 1; i <= 4; i++) begin
            ec++; wc++;
            applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, (i < 4), 1'b1, ec, wc,
                          (i < 4) ? S_LOCKED : S_HUNT);
        end
        applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, ec, wc, S_CHECK);
        applyStimulus(1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0, ec, wc, S_CHECK);
        applyStimulus(1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 1'b0, ec, wc, S_CHECK);
        applyStimulus(1'b1, 8'h90, 1'b1, 1'b0, 1'b0, 1'b0, ec, wc, S_CHECK);
        for (int k = 1; k <= 16; k++)
            applyStimulus(1'b1, 8'(8'h90 + k), 1'b1, 1'b0, (k == 16), 1'b0, ec, wc,
                          (k == 16) ? S_LOCKED : S_CHECK);
        wc++;
        applyStimulus(1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b0, ec, wc, S_LOCKED);

        // Reset beats a pending lock and a coincident clear
        applyStimulus(1'b0, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, S_HUNT);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, S_CHECK);
        for (int k = 1; k <= 15; k++)
            applyStimulus(1'b1, 8'(k), 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, S_CHECK);
        applyStimulus(1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, S_HUNT);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, S_CHECK);
        dinValid = 1'b0;

        applyStimulusSat(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, S_HUNT);
        applyStimulusSat(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, S_CHECK);
        applyStimulusSat(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, S_LOCKED);
        for (int i = 1; i <= 20; i++)
            applyStimulusSat(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, (i < 15) ? i : 15,
                             (i < 15) ? i : 15, S_LOCKED);
        applyStimulusSat(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, S_LOCKED);
        applyStimulusSat(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1, S_LOCKED);
        applyStimulusSat(1'b1, 8'h18, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2, S_LOCKED);
        valid2 = 1'b0;

        repeat (3) @(negedge clk);
        checks++;
        if ((q1.size() != 0) || (q2.size() != 0)) begin
            fails++;
            $display("[TB] FAIL drain: %0d/%0d responses unchecked, expected 0/0", q1.size(), q2.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/zmod_rx_checker.md
Name: zmod_rx_checker

Overview:
Downstream consumer of the LVDS loopback receive path. It runs on the receive clock and takes the 8-bit word assembled from the four IDDR lanes each rxclk. It locks to the transmitter's free-running increment pattern and flywheels through isolated bit errors. It counts errors and good words so the ILA/register view can qualify link margin per IDELAY setting.

Parameters:
WIDTH, 8, captured word width (pattern is a modulo-2^WIDTH up-counter)
LOCK_COUNT, 16, consecutive matching words required to declare lock (>=1)
LOSS_COUNT, 4, consecutive mismatching words in LOCKED that drop lock (>=1)
CNT_W, 32, width of error and word counters

Ports:
clk  in  1  receive-domain clock (rxclk)
rst_n  in  1  synchronous active-low reset
din  in  WIDTH  captured word, {lane3 Q1,Q2 ... lane0 Q1,Q2} ordering as assembled upstream
din_valid  in  1  word qualifier; tie high for continuous capture
clear_counts  in  1  single-cycle pulse; zeroes err_count and word_count
locked  out  1  pattern lock indication
error  out  1  one-cycle pulse per mismatching word while LOCKED
err_count  out  CNT_W  saturating count of mismatches while LOCKED
word_count  out  CNT_W  saturating count of valid words processed while LOCKED
state  out  2  debug: 0=HUNT, 1=CHECK, 2=LOCKED

Behaviour:
- Reset (rst_n low at a clk edge): state=HUNT; locked=0; error=0; err_count=0; word_count=0; internal prev=0, run=0, bad_run=0. All outputs registered.
- din_valid=0: no state, prev, run or counter change; error=0 next cycle. clear_counts is still honoured.
- expected = prev + 1, truncated to WIDTH. 0xFF+1 = 0x00 is a match.
- HUNT: the first valid word loads prev<=din and run<=0, then goes to CHECK. No error is reported.
- CHECK: on each valid word, prev<=din (reseeding on every word).
  - Match: run<=run+1. When run+1 == LOCK_COUNT, go to LOCKED and set locked=1 on that same registered edge. locked is visible the cycle after the LOCK_COUNT-th matching word is presented.
  - Mismatch: run<=0, stay in CHECK. No error pulse, no count.
- LOCKED: on each valid word, prev<=expected (flywheel; din is not reloaded). word_count increments.
  - Match: bad_run<=0.
  - Mismatch: error=1 next cycle; err_count increments; bad_run<=bad_run+1.
  - When bad_run+1 == LOSS_COUNT: go to HUNT, locked=0 next cycle, run=0, bad_run=0. The LOSS_COUNT-th mismatch is still counted and still pulses error.
- Counters saturate at all-ones and never wrap.
- clear_counts has priority over a coincident increment: both counters read 0 next cycle. It does not affect state, lock or error.
- Reset mid-operation overrides everything, including clear_counts and a pending lock transition.
- Latency din -> error/counters/locked: 1 clk.

Test Plan:
- Reset: hold rst_n=0 for 3 clk with random din -> locked=0, error=0, both counts=0, state=0.
- Acquire with wrap: din_valid=1, din=0xF5,0xF6,...,0xFF,0x00,...,0x05 (17 words) -> state CHECK after 0xF5; locked rises the cycle after 0x05; err_count=0; word_count=0 at lock.
- Single-bit error: locked stream ...0x10, 0x11, 0x13 (bit flip), 0x13, 0x14 -> exactly one error pulse after 0x13 #1, err_count=1, locked stays 1; the second 0x13 matches the flywheel.
- Loss of lock: after lock, 4 consecutive words of 0xAA -> 4 error pulses, err_count=4, locked drops the cycle after the 4th; next word reseeds HUNT->CHECK; 16 further matches relock.
- Valid gaps: locked stream 0x20, gap (din_valid=0, din=0x55) x3, 0x21 -> no error, word_count +2, locked held.
- Clear/saturation (CNT_W=4): 20 mismatches in LOCKED with LOSS_COUNT=32 -> err_count=15 held; clear_counts coincident with a mismatch -> err_count=0, error pulse still issued.
